// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial 8-bit ALU controller: latches an operation on Start, processes one
// bit per cycle LSB first, then presents Result/Cout/Zero with a one-cycle Done pulse.
module bit_serial_alu_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Mode,
  input  logic [1:0] Select,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       Cout,
  output logic       Zero
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_XOR = 2'b10;
  localparam logic [1:0] SEL_NOT = 2'b11;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_INC = 2'b10;
  localparam logic [1:0] SEL_DEC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            carry_q,  carry_d;
  logic            mode_q,   mode_d;
  logic [1:0]      sel_q,    sel_d;
  logic [W-1:0]    a_q,      a_d;
  logic [W-1:0]    b_q,      b_d;
  logic [W-1:0]    sh_q,     sh_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q,   cout_d;
  logic            zero_q,   zero_d;

  logic            a_bit_c;
  logic            b_eff_c;
  logic            bit_c;
  logic            carry_nxt_c;
  logic            carry_init_c;
  logic [W-1:0]    sh_nxt_c;

  // Single-bit datapath: operates on the current LSB of the shifting operands.
  always_comb begin
    a_bit_c     = a_q[0];
    b_eff_c     = 1'b0;
    bit_c       = 1'b0;
    carry_nxt_c = 1'b0;
    if (!mode_q) begin
      case (sel_q)
        SEL_AND: bit_c = a_bit_c & b_q[0];
        SEL_OR:  bit_c = a_bit_c | b_q[0];
        SEL_XOR: bit_c = a_bit_c ^ b_q[0];
        SEL_NOT: bit_c = ~a_bit_c;
        default: bit_c = 1'b0;
      endcase
    end else begin
      case (sel_q)
        SEL_ADD: b_eff_c = b_q[0];
        SEL_SUB: b_eff_c = ~b_q[0];
        SEL_INC: b_eff_c = 1'b0;
        SEL_DEC: b_eff_c = 1'b1;
        default: b_eff_c = 1'b0;
      endcase
      bit_c       = a_bit_c ^ b_eff_c ^ carry_q;
      carry_nxt_c = (a_bit_c & b_eff_c) | (a_bit_c & carry_q) | (b_eff_c & carry_q);
    end
    sh_nxt_c = {bit_c, sh_q[W-1:1]};
  end

  // SUB and INC seed the adder with a carry of one; everything else starts at zero.
  always_comb begin
    carry_init_c = Mode & ((Select == SEL_SUB) | (Select == SEL_INC));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          mode_d  = Mode;
          sel_d   = Select;
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          carry_d = carry_init_c;
          sh_d    = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        a_d     = {1'b0, a_q[W-1:1]};
        b_d     = {1'b0, b_q[W-1:1]};
        sh_d    = sh_nxt_c;
        carry_d = carry_nxt_c;
        cnt_d   = cnt_q + CW'(1);
        // Last bit: the counter wraps to zero here and the result is published.
        if (cnt_q == CW'(W - 1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = sh_nxt_c;
          cout_d   = mode_q & carry_nxt_c;
          zero_d   = (sh_nxt_c == '0);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Cout   = cout_q;
  assign Zero   = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_bit_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic       Mode;
  logic [1:0] Select;
  logic [7:0] A;
  logic [7:0] B;
  logic       Busy;
  logic       Done;
  logic [7:0] Result;
  logic       Cout;
  logic       Zero;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_res  = 8'h00;
  logic       exp_cout = 1'b0;

  bit_serial_alu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .Mode   (Mode),
    .Select (Select),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Cout   (Cout),
    .Zero   (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: arithmetic computed with plain integer sums.
  function automatic void ref_op(input logic m, input logic [1:0] s,
                                 input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic c);
    int unsigned sum;
    sum = 0;
    c   = 1'b0;
    if (!m) begin
      case (s)
        2'b00: r = a & b;
        2'b01: r = a | b;
        2'b10: r = a ^ b;
        default: r = ~a;
      endcase
    end else begin
      case (s)
        2'b00: sum = 32'(a) + 32'(b);
        2'b01: sum = 32'(a) + (32'd255 - 32'(b)) + 32'd1;
        2'b10: sum = 32'(a) + 32'd1;
        default: sum = 32'(a) + 32'd255;
      endcase
      r = sum[7:0];
      c = sum[8];
    end
  endfunction

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic busy, input logic done);
    chk({tag, ".busy"}, 32'(Busy), 32'(busy));
    chk({tag, ".done"}, 32'(Done), 32'(done));
    chk({tag, ".result"}, 32'(Result), 32'(exp_res));
    chk({tag, ".cout"}, 32'(Cout), 32'(exp_cout));
    chk({tag, ".zero"}, 32'(Zero), 32'(exp_res == 8'h00));
  endtask

  // Issues one op and checks every cycle from the Start edge to return to IDLE.
  // poke=1 also fires extra Starts mid-run and in the Done cycle.
  task automatic run_op(input string tag, input logic m, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic c, input bit poke);
    @(negedge clk);
    Mode = m; Select = s; A = a; B = b; Start = 1'b1;
    sample();
    Start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); Mode = 1'($urandom); Select = 2'($urandom);
    for (int j = 0; j <= 9; j++) begin
      if (j == 8) begin
        exp_res  = r;
        exp_cout = c;
      end
      check_outputs($sformatf("%s.c%0d", tag, j), j <= 8, j == 8);
      if (poke && (j == 2 || j == 8)) begin
        Start = 1'b1; A = ~a; B = ~b; Mode = ~m; Select = ~s;
      end else begin
        Start = 1'b0;
      end
      if (j < 9) sample();
    end
    Start = 1'b0;
    if (poke) begin
      for (int j = 0; j < 3; j++) begin
        sample();
        check_outputs($sformatf("%s.after%0d", tag, j), 1'b0, 1'b0);
      end
    end
  endtask

  logic [7:0] rr;
  logic       rc;
  logic       rm;
  logic [1:0] rs;
  logic [7:0] ra;
  logic [7:0] rb;

  initial begin
    reset = 1'b1; Start = 1'b1; Mode = 1'b1; Select = 2'b00; A = 8'h12; B = 8'h34;
    sample();
    sample();
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; Start = 1'b0;
    sample();
    check_outputs("post_reset", 1'b0, 1'b0);

    run_op("add_5a_3c", 1'b1, 2'b00, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    run_op("sub_10_01", 1'b1, 2'b01, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0);
    run_op("sub_01_02", 1'b1, 2'b01, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0);
    run_op("add_ff_01", 1'b1, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("dec_00",    1'b1, 2'b11, 8'h00, 8'h77, 8'hFF, 1'b0, 1'b0);
    run_op("inc_ff",    1'b1, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("and",       1'b0, 2'b00, 8'hAA, 8'hF0, 8'hA0, 1'b0, 1'b0);
    run_op("or",        1'b0, 2'b01, 8'hAA, 8'hF0, 8'hFA, 1'b0, 1'b0);
    run_op("xor",       1'b0, 2'b10, 8'hAA, 8'hF0, 8'h5A, 1'b0, 1'b0);
    run_op("not",       1'b0, 2'b11, 8'hAA, 8'hF0, 8'h55, 1'b0, 1'b0);

    run_op("handshake", 1'b1, 2'b00, 8'h21, 8'h43, 8'h64, 1'b0, 1'b1);

    // Abort after four RUN cycles, with Start also high alongside reset.
    @(negedge clk);
    Mode = 1'b1; Select = 2'b00; A = 8'h5A; B = 8'h3C; Start = 1'b1;
    sample();
    Start = 1'b0;
    for (int j = 0; j < 4; j++) sample();
    reset = 1'b1; Start = 1'b1;
    sample();
    reset = 1'b0; Start = 1'b0;
    exp_res  = 8'h00;
    exp_cout = 1'b0;
    check_outputs("abort", 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      sample();
      check_outputs($sformatf("abort_idle%0d", j), 1'b0, 1'b0);
    end
    run_op("add_after_abort", 1'b1, 2'b00, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rm = 1'($urandom);
      rs = 2'($urandom);
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref_op(rm, rs, ra, rb, rr, rc);
      run_op($sformatf("rnd%0d_m%0d_s%0d", n, rm, rs), rm, rs, ra, rb, rr, rc, 1'(n % 8 == 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_ctrl.md
BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 Mode  input  1  0 = logic op, 1 = arithmetic op; latched on accepted Start.
REQ-006 Select  input  2  op select within Mode; latched on accepted Start.
REQ-007 A  input  8  operand A; latched on accepted Start.
REQ-008 B  input  8  operand B; latched on accepted Start.
REQ-009 Busy  output  1  high in RUN and DONE states.
REQ-010 Done  output  1  one-cycle pulse; Result, Cout and Zero are valid from this cycle.
REQ-011 Result  output  8  operation result.
REQ-012 Cout  output  1  final carry of arithmetic ops; 0 for logic ops.
REQ-013 Zero  output  1  high when Result == 8'h00.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
- IDLE -> RUN on Start == 1.
- RUN -> DONE after exactly 8 RUN cycles.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-015 The block SHALL, on an accepted Start, latch Mode, Select, A and B, clear the 3-bit bit counter, and initialise the carry register per REQ-019.
REQ-016 The block SHALL ignore Start while Busy == 1; there is no queueing and the latched operands are not disturbed.
REQ-017 The block SHALL process one bit per RUN cycle, LSB first.
- Bit i = counter value i.
- The computed bit is shifted into the Result shift register at the MSB, with a right shift.
- After 8 RUN cycles, Result[i] holds bit i.
REQ-018 Logic ops (Mode = 0) SHALL be computed per bit:
- Select 00 = A AND B
- Select 01 = A OR B
- Select 10 = A XOR B
- Select 11 = NOT A
- Carry is unused; Cout = 0.
REQ-019 Arithmetic ops (Mode = 1) SHALL be a full-adder per bit: sum = a ^ b' ^ c; c_next = majority(a, b', c).
- Select 00 ADD: b' = B bit, carry init 0.
- Select 01 SUB: b' = NOT B bit, carry init 1.
- Select 10 INC: b' = 0, carry init 1.
- Select 11 DEC: b' = 1, carry init 0.
REQ-020 The block SHALL meet this latency: Start sampled at edge k -> RUN during edges k+1..k+8 -> Done high for the single cycle following edge k+8 -> IDLE after edge k+9.
- The next Start is accepted at edge k+10 at the earliest.
REQ-021 The block SHALL update Cout and Zero on the same edge that asserts Done.
- Result, Cout and Zero SHALL hold their values until the next Done or reset.
- Intermediate shifting of the internal register SHALL NOT be visible on Result; Result is a separate output register loaded at DONE entry.
REQ-022 For arithmetic ops, the block SHALL report Cout as the carry out of bit 7.
- SUB: Cout = 1 means no borrow (A >= B).
- DEC of 8'h00 gives Result 8'hFF with Cout = 0.
REQ-023 The bit counter SHALL wrap from 7 to 0 exactly at RUN exit.
- No ninth bit is processed.
- Operand registers are not shifted beyond 8 positions.

Reset
REQ-024 On reset == 1 at a clock edge, the block SHALL enter IDLE and clear all internal registers: counter, carry, latched operands and shift register.
- Outputs after reset: Busy 0, Done 0, Result 8'h00, Cout 0, Zero 1.
REQ-025 Reset SHALL take priority over Start and over any state transition.
- Reset asserted mid-RUN aborts the operation with no Done pulse.
- The partial result SHALL NOT appear on Result.
REQ-026 Start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-027 ADD: Mode = 1, Select = 00, A = 8'h5A, B = 8'h3C, Start pulse.
- Busy high for 9 cycles.
- Done in the 9th cycle after the Start edge.
- Result 8'h96, Cout 0, Zero 0.
REQ-028 SUB: Mode = 1, Select = 01, A = 8'h10, B = 8'h01 -> Result 8'h0F, Cout 1.
- Then A = 8'h01, B = 8'h02 -> Result 8'hFF, Cout 0.
REQ-029 Overflow: ADD with A = 8'hFF, B = 8'h01 -> Result 8'h00, Cout 1, Zero 1.
- DEC with A = 8'h00 -> Result 8'hFF, Cout 0.
REQ-030 Logic ops with A = 8'hAA, B = 8'hF0, one run per Select:
- Select 00 -> 8'hA0; Select 01 -> 8'hFA; Select 10 -> 8'h5A; Select 11 -> 8'h55.
- Cout 0 in all cases.
REQ-031 Handshake: a second Start with different operands, issued 3 cycles after an accepted Start, SHALL be ignored.
- Done occurs exactly once, with the first operation's result.
- A Start in the DONE cycle is also ignored.
REQ-032 Reset mid-op: reset after 4 RUN cycles -> next cycle Busy 0, Result 8'h00, Zero 1, and no Done pulse.
- A fresh Start afterwards SHALL complete normally per REQ-027.
